// File: rtl/bsw_pkg.sv
// Shared definitions for the banded Smith-Waterman max-reduction logic:
// geometry, default widths, controller states and a PE slice helper.
package bsw_pkg;

    localparam int NPE       = 4;
    localparam int HW        = 7;
    localparam int CNT_W_DEF = 10;
    localparam int XDROP_DEF = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bsw_state_e;

    function automatic logic [HW-1:0] h_slice(input logic [NPE*HW-1:0] h, input int unsigned k);
        return h[k*HW +: HW];
    endfunction

endpackage

// File: rtl/pe_max_sel.sv
// Combinational max over the PE scores of one beat, returning the value and
// the index of the lowest-numbered PE holding it.
module pe_max_sel
    import bsw_pkg::*;
(
    input  logic [NPE*HW-1:0] h_in,
    output logic [HW-1:0]     max_val,
    output logic [1:0]        max_idx
);

    // Strict compare while scanning upward keeps the lowest index on ties.
    always_comb begin
        max_val = h_slice(h_in, 0);
        max_idx = 2'd0;
        for (int unsigned k = 1; k < NPE; k++) begin
            if (h_slice(h_in, k) > max_val) begin
                max_val = h_slice(h_in, k);
                max_idx = 2'(k);
            end
        end
    end

endmodule

// File: rtl/max_score_tracker.sv
// Tracks the best PE score (with PE index and beat number) over one alignment,
// raises a sticky X-drop request and pulses done once the pipeline has drained.
//
// state    | meaning
// ST_IDLE  | out of reset, waiting for start
// ST_RUN   | accepting beats until the one tagged last
// ST_DRAIN | last beat accepted, waiting for stage 1 to empty
// ST_DONE  | results final, held until the next start
module max_score_tracker
    import bsw_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int XDROP = XDROP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              valid_in,
    input  logic              last_in,
    input  logic [NPE*HW-1:0] H_in,
    output logic              busy,
    output logic              done,
    output logic              xdrop,
    output logic [HW-1:0]     max_score,
    output logic [1:0]        max_pe,
    output logic [CNT_W-1:0]  max_beat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [HW-1:0]    XDROP_H = HW'(XDROP);

    bsw_state_e       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_first_q, s1_first_d;
    logic [HW-1:0]    s1_max_q, s1_max_d;
    logic [1:0]       s1_pe_q, s1_pe_d;
    logic [CNT_W-1:0] s1_beat_q, s1_beat_d;
    logic [HW-1:0]    max_score_q, max_score_d;
    logic [1:0]       max_pe_q, max_pe_d;
    logic [CNT_W-1:0] max_beat_q, max_beat_d;
    logic             xdrop_q, xdrop_d;
    logic             done_q, done_d;

    logic [HW-1:0]    grp_max;
    logic [1:0]       grp_idx;
    logic             accept;

    pe_max_sel u_pe_max_sel (
        .h_in    (H_in),
        .max_val (grp_max),
        .max_idx (grp_idx)
    );

    assign accept = (state_q == ST_RUN) && valid_in;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        s1_valid_d  = accept;
        s1_first_d  = s1_first_q;
        s1_max_d    = s1_max_q;
        s1_pe_d     = s1_pe_q;
        s1_beat_d   = s1_beat_q;
        max_score_d = max_score_q;
        max_pe_d    = max_pe_q;
        max_beat_d  = max_beat_q;
        xdrop_d     = xdrop_q;
        done_d      = 1'b0;

        // Stage 2 runs before the FSM clears; the pipe is always empty in IDLE/DONE.
        if (s1_valid_q) begin
            if (!s1_first_q && (max_score_q > s1_max_q) && ((max_score_q - s1_max_q) > XDROP_H)) begin
                xdrop_d = 1'b1;
            end
            if (s1_first_q || (s1_max_q > max_score_q)) begin
                max_score_d = s1_max_q;
                max_pe_d    = s1_pe_q;
                max_beat_d  = s1_beat_q;
            end
        end

        if (accept) begin
            s1_max_d   = grp_max;
            s1_pe_d    = grp_idx;
            s1_beat_d  = beat_cnt_q;
            s1_first_d = (beat_cnt_q == '0);
            if (beat_cnt_q != CNT_MAX) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    beat_cnt_d  = '0;
                    xdrop_d     = 1'b0;
                    max_score_d = '0;
                    max_pe_d    = '0;
                    max_beat_d  = '0;
                end
            end
            ST_RUN: begin
                if (accept && last_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_max_q    <= '0;
            s1_pe_q     <= '0;
            s1_beat_q   <= '0;
            max_score_q <= '0;
            max_pe_q    <= '0;
            max_beat_q  <= '0;
            xdrop_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_max_q    <= s1_max_d;
            s1_pe_q     <= s1_pe_d;
            s1_beat_q   <= s1_beat_d;
            max_score_q <= max_score_d;
            max_pe_q    <= max_pe_d;
            max_beat_q  <= max_beat_d;
            xdrop_q     <= xdrop_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign xdrop     = xdrop_q;
    assign max_score = max_score_q;
    assign max_pe    = max_pe_q;
    assign max_beat  = max_beat_q;

endmodule

// File: tb/tb_max_score_tracker.sv
// Self-checking bench for max_score_tracker: fixed vector table, hand-written
// protocol/timing sequences and randomized runs against a reference model.
module tb_max_score_tracker;

    logic        clk = 1'b0;
    logic        rst, start, valid_in, last_in;
    logic [27:0] H_in;
    logic        busy, done, xdrop;
    logic [6:0]  max_score;
    logic [1:0]  max_pe;
    logic [9:0]  max_beat;

    int n_chk  = 0;
    int n_fail = 0;

    logic [27:0] q_beats[$];

    typedef struct {
        int          n;
        logic [27:0] h[4];
        logic [6:0]  e_score;
        logic [1:0]  e_pe;
        logic [9:0]  e_beat;
        logic        e_xdrop;
    } vec_t;

    vec_t vt[7];

    max_score_tracker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .H_in      (H_in),
        .busy      (busy),
        .done      (done),
        .xdrop     (xdrop),
        .max_score (max_score),
        .max_pe    (max_pe),
        .max_beat  (max_beat)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] mk(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    function automatic vec_t mkv(input int n, input logic [27:0] a, input logic [27:0] b,
                                 input logic [27:0] c, input logic [27:0] d, input int s,
                                 input int p, input int bt, input int x);
        vec_t v;
        v.n = n; v.h[0] = a; v.h[1] = b; v.h[2] = c; v.h[3] = d;
        v.e_score = 7'(s); v.e_pe = 2'(p); v.e_beat = 10'(bt); v.e_xdrop = 1'(x);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_run();
        valid_in = 1'b0; last_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Returns number of steps taken since the cycle after the last beat; 3 means on time.
    task automatic wait_done(output int waited);
        waited = 1;
        while (!done && waited < 10) begin
            step();
            waited++;
        end
    endtask

    task automatic run_q(input int gap_max, input string tag);
        logic [6:0] e_s, g;
        logic [1:0] e_p, gi;
        logic [9:0] e_b;
        logic       e_x;
        int         n, dones, waited;
        n = q_beats.size();
        e_s = 0; e_p = 0; e_b = 0; e_x = 0;
        for (int i = 0; i < n; i++) begin
            g = q_beats[i][6:0]; gi = 0;
            for (int k = 1; k < 4; k++) begin
                if (7'(q_beats[i] >> (7*k)) > g) begin
                    g  = 7'(q_beats[i] >> (7*k));
                    gi = 2'(k);
                end
            end
            if (i > 0 && e_s > g && int'(e_s) - int'(g) > 20) e_x = 1;
            if (i == 0 || g > e_s) begin
                e_s = g; e_p = gi; e_b = (i > 1023) ? 10'd1023 : 10'(i);
            end
        end
        dones = 0;
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1; H_in = q_beats[i]; last_in = (i == n-1);
            step();
            if (done) dones++;
            if (i != n-1) begin
                int gaps;
                gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
                for (int j = 0; j < gaps; j++) begin
                    valid_in = 1'b0; last_in = 1'($urandom); H_in = 28'($urandom);
                    step();
                    if (done) dones++;
                end
            end
        end
        valid_in = 1'b0; last_in = 1'b0;
        chk({tag, "_early_done"}, 32'(dones), 32'd0);
        wait_done(waited);
        chk({tag, "_done_latency"}, 32'(waited), 32'd3);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_score"}, 32'(max_score), 32'(e_s));
        chk({tag, "_pe"}, 32'(max_pe), 32'(e_p));
        chk({tag, "_beat"}, 32'(max_beat), 32'(e_b));
        chk({tag, "_xdrop"}, 32'(xdrop), 32'(e_x));
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int w, dcnt;
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; last_in = 1'b0; H_in = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_xdrop", 32'(xdrop), 32'd0);
        chk("rst_score", 32'(max_score), 32'd0);
        chk("rst_pe", 32'(max_pe), 32'd0);
        chk("rst_beat", 32'(max_beat), 32'd0);
        rst = 1'b0;
        step();

        // Protocol: beats in IDLE ignored
        valid_in = 1'b1; last_in = 1'b1; H_in = mk(100, 0, 0, 0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin step(); if (done) dcnt++; end
        valid_in = 1'b0; last_in = 1'b0;
        step();
        chk("idle_valid_busy", 32'(busy), 32'd0);
        chk("idle_valid_score", 32'(max_score), 32'd0);
        chk("idle_valid_done", 32'(dcnt), 32'd0);

        // Protocol: start in RUN and last without valid ignored
        start_run();
        valid_in = 1'b1; H_in = mk(10, 0, 0, 0);
        step();
        valid_in = 1'b0; H_in = mk(120, 120, 120, 120);
        step(); step();
        chk("proto_first_score", 32'(max_score), 32'd10);
        start = 1'b1; step(); start = 1'b0;
        last_in = 1'b1; step(); last_in = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin step(); if (done) dcnt++; end
        chk("proto_still_busy", 32'(busy), 32'd1);
        chk("proto_no_done", 32'(dcnt), 32'd0);
        chk("proto_score_kept", 32'(max_score), 32'd10);
        valid_in = 1'b1; last_in = 1'b1; H_in = mk(5, 0, 0, 0);
        step();
        valid_in = 1'b0; last_in = 1'b0;
        wait_done(w);
        chk("proto_latency", 32'(w), 32'd3);
        chk("proto_score", 32'(max_score), 32'd10);
        chk("proto_beat", 32'(max_beat), 32'd0);
        step();

        // Reset mid-run
        start_run();
        valid_in = 1'b1; H_in = mk(60, 0, 0, 0); step();
        H_in = mk(0, 0, 70, 0); step();
        valid_in = 1'b0; rst = 1'b1;
        step();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_score", 32'(max_score), 32'd0);
        chk("midrst_pe", 32'(max_pe), 32'd0);
        chk("midrst_beat", 32'(max_beat), 32'd0);
        chk("midrst_xdrop", 32'(xdrop), 32'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin step(); if (done || busy) dcnt++; end
        chk("midrst_quiet", 32'(dcnt), 32'd0);

        // Vector table
        vt[0] = mkv(3, mk(5,9,9,2), mk(3,3,3,3), mk(1,8,0,0), 0, 9, 1, 0, 0);
        vt[1] = mkv(2, mk(7,0,0,0), mk(0,0,0,7), 0, 0, 7, 0, 0, 0);
        vt[2] = mkv(3, mk(40,0,0,0), mk(19,19,19,19), mk(50,0,0,0), 0, 50, 0, 2, 1);
        vt[3] = mkv(1, mk(3,6,6,6), 0, 0, 0, 6, 1, 0, 0);
        vt[4] = mkv(4, mk(10,20,30,40), mk(40,0,0,41), mk(127,127,0,0), mk(100,0,0,0), 127, 0, 2, 1);
        vt[5] = mkv(2, mk(30,0,0,0), mk(10,0,0,0), 0, 0, 30, 0, 0, 0);
        vt[6] = mkv(2, mk(30,0,0,0), mk(9,0,0,0), 0, 0, 30, 0, 0, 1);
        for (int v = 0; v < 7; v++) begin
            q_beats.delete();
            for (int i = 0; i < vt[v].n; i++) q_beats.push_back(vt[v].h[i]);
            start_run();
            run_q(1, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tab_score", v), 32'(max_score), 32'(vt[v].e_score));
            chk($sformatf("vec%0d_tab_pe", v), 32'(max_pe), 32'(vt[v].e_pe));
            chk($sformatf("vec%0d_tab_beat", v), 32'(max_beat), 32'(vt[v].e_beat));
            chk($sformatf("vec%0d_tab_xdrop", v), 32'(xdrop), 32'(vt[v].e_xdrop));
        end

        // X-drop timing and clear on start
        start_run();
        valid_in = 1'b1; H_in = mk(40, 0, 0, 0); step();
        H_in = mk(19, 19, 19, 19); step();
        valid_in = 1'b0;
        chk("xd_t1", 32'(xdrop), 32'd0);
        step();
        chk("xd_t2", 32'(xdrop), 32'd1);
        valid_in = 1'b1; last_in = 1'b1; H_in = mk(50, 0, 0, 0); step();
        valid_in = 1'b0; last_in = 1'b0;
        wait_done(w);
        chk("xd_latency", 32'(w), 32'd3);
        chk("xd_score", 32'(max_score), 32'd50);
        chk("xd_sticky", 32'(xdrop), 32'd1);
        step();
        chk("xd_hold", 32'(xdrop), 32'd1);
        start_run();
        chk("xd_cleared", 32'(xdrop), 32'd0);
        chk("xd_score_cleared", 32'(max_score), 32'd0);

        // Start coincident with done
        valid_in = 1'b1; last_in = 1'b1; H_in = mk(9, 0, 0, 0); step();
        valid_in = 1'b0; last_in = 1'b0;
        step(); step();
        chk("coinc_done", 32'(done), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        chk("coinc_done_off", 32'(done), 32'd0);
        chk("coinc_busy", 32'(busy), 32'd1);
        chk("coinc_score_clr", 32'(max_score), 32'd0);
        q_beats.delete();
        q_beats.push_back(mk(4, 0, 0, 0));
        run_q(0, "coinc_run");

        // Long runs: 1030 flat beats, then saturation of the beat number
        q_beats.delete();
        for (int i = 0; i < 1030; i++) q_beats.push_back(mk(1, 1, 1, 1));
        start_run();
        run_q(0, "flat1030");
        q_beats.delete();
        for (int i = 0; i < 1025; i++) q_beats.push_back(mk(1, 1, 1, 1));
        q_beats.push_back(mk(0, 2, 0, 0));
        start_run();
        run_q(0, "sat");
        chk("sat_beat_max", 32'(max_beat), 32'd1023);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int n;
            q_beats.delete();
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++)
                q_beats.push_back(mk(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                                     int'($urandom_range(0, 127)), int'($urandom_range(0, 127))));
            start_run();
            run_q(2, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
